// File: rtl/dvs_on_hssl_top.sv
// DVS event link over a single-lane HSSL: frame generator, aligner, checker.
// Optional DVS_HSSL_PARITY_EN puts even parity of payload[30:0] in payload[31].
module dvs_on_hssl_top #(
  parameter int unsigned EVT_GAP  = 4,
  parameter int unsigned LOCK_CNT = 16
) (
  input  logic        gt_refclk_p,
  input  logic        gt_refclk_n,
  input  logic        reset,
  input  logic        gt_rxp_in,
  input  logic        gt_rxn_in,
  output logic        gt_txp_out,
  output logic        gt_txn_out,
  output logic        rx_locked,
  output logic [31:0] rx_event_count,
  output logic [15:0] rx_error_count
);

  localparam logic [5:0]  LAST_BIT = 6'd33;
  localparam logic [7:0]  GAP      = EVT_GAP[7:0];
  localparam logic [15:0] LOCK     = LOCK_CNT[15:0];

  typedef enum logic {
    RX_HUNT,
    RX_LOCK
  } rx_state_e;

  // Differential complements carry no extra information here.
  logic unused_inputs;
  assign unused_inputs = gt_refclk_n ^ gt_rxn_in;

  // ---------------- transmit ----------------
  logic [5:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] gen_q, gen_d;
  logic        tx_is_evt;
  logic [31:0] tx_pay;
  logic [33:0] tx_frame;
  logic        tx_bit;

  assign tx_is_evt = (gap_q == GAP);

`ifdef DVS_HSSL_PARITY_EN
  assign tx_pay = {^gen_q[30:0], gen_q[30:0]};
`else
  assign tx_pay = gen_q;
`endif

  assign tx_frame = tx_is_evt ? {2'b01, tx_pay} : {2'b10, 32'h0000_0000};
  assign tx_bit   = tx_frame[LAST_BIT - tx_bit_q];

  // Output is forced low while reset is held so an aborted frame stops at once.
  assign gt_txp_out = ~reset & tx_bit;
  assign gt_txn_out = ~gt_txp_out;

  // Advance the bit pointer; at frame end step the idle/event schedule.
  always_comb begin
    tx_bit_d = tx_bit_q + 6'd1;
    gap_d    = gap_q;
    gen_d    = gen_q;
    if (tx_bit_q == LAST_BIT) begin
      tx_bit_d = 6'd0;
      if (tx_is_evt) begin
        gap_d = 8'd0;
        gen_d = gen_q + 32'd1;
      end else begin
        gap_d = gap_q + 8'd1;
      end
    end
  end

  // Transmit state registers.
  always_ff @(posedge gt_refclk_p or posedge reset) begin
    if (reset) begin
      tx_bit_q <= 6'd0;
      gap_q    <= 8'd0;
      gen_q    <= 32'd0;
    end else begin
      tx_bit_q <= tx_bit_d;
      gap_q    <= gap_d;
      gen_q    <= gen_d;
    end
  end

  // ---------------- receive ----------------
  rx_state_e   state_q, state_d;
  logic [33:0] rx_sr_q, rx_sr_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;
  logic        slip_q, slip_d;
  logic [15:0] good_q, good_d;
  logic [31:0] exp_q, exp_d;
  logic        exp_vld_q, exp_vld_d;
  logic [31:0] evt_q, evt_d;
  logic [15:0] err_q, err_d;
  logic        err_inc;

  logic [33:0] rx_word;
  logic [1:0]  hdr;
  logic [31:0] pay;
  logic        hdr_ok;
  logic        hdr_evt;
  logic        par_bad;
  logic        mism;

  // Word as it stands once the current bit is shifted in.
  assign rx_word = {rx_sr_q[32:0], gt_rxp_in};
  assign hdr     = rx_word[33:32];
  assign pay     = rx_word[31:0];
  assign hdr_ok  = (hdr == 2'b01) || (hdr == 2'b10);
  assign hdr_evt = (hdr == 2'b01);

`ifdef DVS_HSSL_PARITY_EN
  assign par_bad = pay[31] ^ (^pay[30:0]);
  assign mism    = (pay[30:0] != exp_q[30:0]);
`else
  assign par_bad = 1'b0;
  assign mism    = (pay != exp_q);
`endif

  assign rx_locked      = (state_q == RX_LOCK);
  assign rx_event_count = evt_q;
  assign rx_error_count = err_q;

  // Alignment search, lock tracking and event payload checking.
  always_comb begin
    state_d   = state_q;
    rx_sr_d   = rx_word;
    rx_cnt_d  = rx_cnt_q + 6'd1;
    slip_d    = 1'b0;
    good_d    = good_q;
    exp_d     = exp_q;
    exp_vld_d = exp_vld_q;
    evt_d     = evt_q;
    err_d     = err_q;
    err_inc   = 1'b0;

    if (slip_q) begin
      // Hold the counter one extra bit to shift the alignment.
      rx_cnt_d = rx_cnt_q;
    end else if (rx_cnt_q == LAST_BIT) begin
      rx_cnt_d = 6'd0;
      unique case (state_q)
        RX_HUNT: begin
          if (hdr_ok) begin
            good_d = good_q + 16'd1;
            if (good_d == LOCK) begin
              state_d   = RX_LOCK;
              exp_vld_d = 1'b0;
            end
          end else begin
            good_d = 16'd0;
            slip_d = 1'b1;
          end
        end
        RX_LOCK: begin
          if (!hdr_ok) begin
            state_d   = RX_HUNT;
            good_d    = 16'd0;
            slip_d    = 1'b1;
            exp_vld_d = 1'b0;
            err_inc   = 1'b1;
          end else if (hdr_evt) begin
            evt_d = evt_q + 32'd1;
            if (!exp_vld_q) begin
              exp_d     = pay + 32'd1;
              exp_vld_d = 1'b1;
            end else if (par_bad) begin
              // Corrupt payload cannot be trusted to resync the sequence.
              err_inc = 1'b1;
              exp_d   = exp_q + 32'd1;
            end else begin
              err_inc = mism;
              exp_d   = pay + 32'd1;
            end
          end
        end
        default: state_d = RX_HUNT;
      endcase
    end

    if (err_inc && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  // Receive state registers.
  always_ff @(posedge gt_refclk_p or posedge reset) begin
    if (reset) begin
      state_q   <= RX_HUNT;
      rx_sr_q   <= 34'd0;
      rx_cnt_q  <= 6'd0;
      slip_q    <= 1'b0;
      good_q    <= 16'd0;
      exp_q     <= 32'd0;
      exp_vld_q <= 1'b0;
      evt_q     <= 32'd0;
      err_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      rx_sr_q   <= rx_sr_d;
      rx_cnt_q  <= rx_cnt_d;
      slip_q    <= slip_d;
      good_q    <= good_d;
      exp_q     <= exp_d;
      exp_vld_q <= exp_vld_d;
      evt_q     <= evt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_dvs_on_hssl_top.sv
// Directed bench for dvs_on_hssl_top: TX pattern, loopback lock,
// link break, async reset, single-bit corruption, inverted loopback.
module tb_dvs_on_hssl_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rxp;
  logic        rxn;
  logic        txp;
  logic        txn;
  logic        locked;
  logic [31:0] ev;
  logic [15:0] err;

  int   mode = 0;
  logic flip_en = 1'b0;
  int   cyc;
  int   nrun = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  // mode 0: loopback, 1: line stuck low, 2: polarity swapped
  assign rxp = (mode == 1) ? 1'b0 :
               (mode == 2) ? txn :
               (txp ^ (flip_en && (cyc == 830)));
  assign rxn = ~rxp;

  // Edges since reset release; equals index of the bit on the line.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  dvs_on_hssl_top #(
    .EVT_GAP(4),
    .LOCK_CNT(16)
  ) dut (
    .gt_refclk_p   (clk),
    .gt_refclk_n   (~clk),
    .reset         (reset),
    .gt_rxp_in     (rxp),
    .gt_rxn_in     (rxn),
    .gt_txp_out    (txp),
    .gt_txn_out    (txn),
    .rx_locked     (locked),
    .rx_event_count(ev),
    .rx_error_count(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nrun++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_lock(input int bound);
    for (int i = 0; i < bound && !locked; i++) @(negedge clk);
  endtask

  logic [33:0] fr;
  int          inv_bad;

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txp", txp, 0);
    chk("rst_txn", txn, 1);
    chk("rst_lock", locked, 0);
    chk("rst_ev", ev, 0);
    chk("rst_err", err, 0);

    // Capture 170 line bits, one per cycle, starting right at release.
    @(negedge clk);
    reset = 1'b0;
    inv_bad = 0;
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 34; b++) begin
        #1;
        fr[33-b] = txp;
        if (txn !== ~txp) inv_bad++;
        @(negedge clk);
      end
      if (f < 4) chk("tx_idle", fr, 34'h2_0000_0000);
      else       chk("tx_evt0", fr, 34'h1_0000_0000);
    end
    chk("tx_txn_inv", inv_bad, 0);

    // Lock lands on the 16th boundary, edge 16*34.
    wait_lock(2000);
    chk("lock", locked, 1);
    chk("lock_cyc", cyc, 544);
    chk("lock_err0", err, 0);
    wait_until(700);
    chk("ev_1", ev, 1);
    wait_until(870);
    chk("ev_2", ev, 2);
    wait_until(1040);
    chk("ev_3", ev, 3);
    chk("ev_err0", err, 0);

    // Break the line at a frame boundary; next header is 00.
    wait_until(1054);
    mode = 1;
    wait_until(1088);
    chk("brk_lock", locked, 0);
    chk("brk_err", err, 1);
    chk("brk_ev", ev, 3);
    mode = 0;
    wait_lock(2000);
    chk("relock", locked, 1);
    chk("relock_err", err, 1);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("ares_lock", locked, 0);
    chk("ares_ev", ev, 0);
    chk("ares_err", err, 0);
    chk("ares_txp", txp, 0);
    chk("ares_txn", txn, 1);
    @(negedge clk);
    reset = 1'b0;
    flip_en = 1'b1;
    wait_lock(2000);
    chk("ares_relock", locked, 1);
    chk("ares_lockcyc", cyc, 544);

    // Payload bit 19 of event #4 (frame 24) is flipped on the wire.
    wait_until(860);
    chk("flip_err_a", err, 1);
    wait_until(1030);
`ifdef DVS_HSSL_PARITY_EN
    chk("flip_err_b", err, 1);
`else
    chk("flip_err_b", err, 2);
`endif
    chk("flip_lock", locked, 1);
    chk("flip_ev", ev, 3);
    flip_en = 1'b0;

    // Swapped polarity: idles look like events with payload FFFF_FFFF.
    @(negedge clk);
    reset = 1'b1;
    mode = 2;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_until(720);
    chk("inv_lock", locked, 1);
    chk("inv_ev", ev, 4);
    chk("inv_err", err, 3);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
